shift_unit_pipelined: RTL and testbench
=======================================

// Module: shift_unit_pipelined
// PURPOSE
//  Parametrised, pipelined shifter for the ALU. Handles SLL, SRL, SRA, ROL and ROR on an
//  N-bit operand with a full-width shift amount. Data flows in and out over valid/ready
//  handshakes, so the unit can sit between the register-read stage and writeback and
//  absorb backpressure. A sideband tag travels with each operation.
// PARAMETERS
//  N      32  operand width; power of two, >= 8
//  STAGES 2   register stages; latency in cycles, 1..$clog2(N)
//  TAG_W  5   width of the sideband tag (e.g. destination register index)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operation presented
//  in_ready   out  1      unit accepts the operation this cycle
//  in_data    in   N      operand
//  in_shamt   in   N      shift amount, full word, unsigned
//  in_op      in   3      000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101-111 reserved
//  in_tag     in   TAG_W  sideband, returned unchanged with the result
//  out_valid  out  1      result presented
//  out_ready  in   1      consumer accepts the result
//  out_data   out  N      result
//  out_tag    out  TAG_W  tag of the result
//  out_illegal out 1      result came from a reserved opcode
// BEHAVIOUR
//  - One clock domain. Reset: asynchronous, active-high.
//  - Reset values: every stage valid bit = 0, out_valid = 0, out_data = 0, out_tag = 0,
//    out_illegal = 0.
//  - Reset asserted mid-operation discards every in-flight operation. Nothing is replayed.
//  - Transfer rules:
//    - An input transfer happens when in_valid && in_ready.
//    - An output transfer happens when out_valid && out_ready.
//  - Pipeline: stage k holds valid_k. Stage k advances when !valid_k || advance_{k+1}.
//    The last stage advances when !out_valid || out_ready.
//  - in_ready is the stage-0 advance term. It depends combinationally on out_ready and
//    on the stage valid bits only, never on in_valid.
//  - Bubbles collapse: an empty stage accepts new data even while later stages are stalled.
//  - Latency:
//    - Without stall, a result is out_valid exactly STAGES cycles after the input transfer.
//    - Throughput is 1 operation per cycle.
//    - Ordering is strict FIFO.
//  - While out_valid && !out_ready, out_data, out_tag and out_illegal stay stable.
//  - Shift decomposition: a log2(N)-level barrel network, level i shifting by 2^i.
//    Levels are split across STAGES as evenly as possible, with earlier stages taking
//    ceil(levels/STAGES). Each stage registers its partial result, sign bit, op and tag.
//  - Out-of-range amounts use hi = |in_shamt[N-1:$clog2(N)]:
//    - SLL/SRL with hi = 1: result 0.
//    - SRA with hi = 1: result is in_data[N-1] replicated to all N bits.
//    - ROL/ROR: the amount is in_shamt mod N (low bits only). hi is ignored.
//  - Fill rules:
//    - SRA fills with the original in_data[N-1], latched at input.
//    - SRL and SLL fill with 0.
//    - Rotates move bits across the boundary with no loss.
//  - Reserved op: the operation flows through the pipe normally with
//    out_data = 0 and out_illegal = 1.
//  - Shift by 0 returns in_data unchanged for every legal op.
// TESTING
//  1. N=32, STAGES=2, back-to-back input, out_ready=1:
//     - Op 1: SLL 0x0000_0001 by 31 -> 0x8000_0000.
//     - Op 2: SRA 0x8000_0000 by 4 -> 0xF800_0000.
//     - Results appear on cycles +2 and +3, tags preserved.
//  2. Out of range:
//     - SLL 0xFFFF_FFFF by 32 -> 0.
//     - SRA 0x8000_0001 by 0x100 -> 0xFFFF_FFFF.
//     - SRL 0x8000_0000 by 0xFFFF_FFFF -> 0.
//  3. Rotates:
//     - ROL 0x8000_0001 by 1 -> 0x0000_0003.
//     - ROR 0x0000_0001 by 33 -> 0x8000_0000.
//  4. Backpressure:
//     - Hold out_ready=0 for 5 cycles while streaming 4 ops.
//     - in_ready drops once all STAGES+1 slots are full.
//     - out_data is stable throughout.
//     - Release out_ready: 4 results in order, none lost or duplicated.
//  5. Reserved op 111 with tag 7 -> out_illegal=1, out_data=0, out_tag=7. The next legal op
//     is unaffected.
//  6. Assert rst with 2 ops in flight -> out_valid=0 immediately. No stale results after
//     release. Repeat test 1 with STAGES=1 and STAGES=5, checking latency 1 and 5.

Source files
------------

// File: rtl/shift_unit_pipelined.sv
// shift_unit_pipelined: valid/ready pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR).
//   clk, rst                      clock, async active-high reset
//   in_valid/in_ready             input handshake
//   in_data, in_shamt, in_op      operand, full-width amount, opcode
//   in_tag                        sideband returned with the result
//   out_valid/out_ready           output handshake
//   out_data, out_tag, out_illegal result, its tag, reserved-opcode flag
//
// Every op is folded into a right-shift network: left ops bit-reverse the operand
// on entry and the result on exit. Out-of-range SLL/SRL/SRA are resolved on entry
// by replacing the operand with 0 / all-sign, which any further shift leaves intact.
// Slot 0 is a skid register in front of stage 1. With no stall an op bypasses it and
// lands directly in stage 1, so latency is STAGES while capacity is STAGES+1.

module shift_levels #(
  parameter int N   = 32,
  parameter int LO  = 0,
  parameter int CNT = 1
) (
  input  logic [N-1:0]   data,
  input  logic [CNT-1:0] amt,
  input  logic           fill,
  input  logic           rot,
  output logic [N-1:0]   res
);
  always_comb begin
    res = data;
    for (int i = LO; i < LO + CNT; i++) begin
      if (amt[i-LO]) begin
        if (rot) res = (res >> (1 << i)) | (res << (N - (1 << i)));
        else     res = (res >> (1 << i)) | (fill ? ~({N{1'b1}} >> (1 << i)) : '0);
      end
    end
  end
endmodule

module shift_unit_pipelined #(
  parameter int N      = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic [N-1:0]     in_shamt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  localparam int LW   = $clog2(N);
  localparam int BASE = LW / STAGES;
  localparam int REM  = LW % STAGES;

  typedef struct packed {
    logic [N-1:0]     data;
    logic [LW-1:0]    amt;
    logic             fill;  // bit shifted in by non-rotate ops
    logic             rot;
    logic             rev;   // result must be bit-reversed on exit
    logic             ill;
    logic [TAG_W-1:0] tag;
  } pay_t;

  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] adv;
  logic [STAGES:1] up_vld;
  pay_t            pipe [0:STAGES];
  pay_t            nxt  [1:STAGES];
  pay_t            pre, src;
  logic [N-1:0]    rin, rout;
  logic            hi;

  // Entry decode
  always_comb begin
    hi = |in_shamt[N-1:LW];
    for (int i = 0; i < N; i++) rin[i] = in_data[N-1-i];
    pre     = '0;
    pre.amt = in_shamt[LW-1:0];
    pre.tag = in_tag;
    case (in_op)
      3'b000: begin pre.rev = 1'b1; pre.data = hi ? '0 : rin; end
      3'b001: pre.data = hi ? '0 : in_data;
      3'b010: begin
        pre.fill = in_data[N-1];
        pre.data = hi ? {N{in_data[N-1]}} : in_data;
      end
      3'b011: begin pre.rev = 1'b1; pre.rot = 1'b1; pre.data = rin; end
      3'b100: begin pre.rot = 1'b1; pre.data = in_data; end
      default: pre.ill = 1'b1;  // data stays 0
    endcase
  end

  // A stage advances if it or any later slot is empty, or the consumer takes the head.
  for (genvar k = 0; k <= STAGES; k++) begin : g_adv
    assign adv[k] = out_ready || !(&vld_pipe[STAGES:k]);
  end
  assign in_ready = adv[0];

  // Skid slot feeds stage 1 when occupied, otherwise the live input bypasses it.
  assign src = vld_pipe[0] ? pipe[0] : pre;

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    localparam int J   = k - 1;
    localparam int CNT = BASE + ((J < REM) ? 1 : 0);
    localparam int LO  = J * BASE + ((J < REM) ? J : REM);
    pay_t         sin, nx;
    logic [N-1:0] res;
    if (k == 1) begin : g_first
      assign sin       = src;
      assign up_vld[k] = vld_pipe[0] | in_valid;
    end else begin : g_rest
      assign sin       = pipe[k-1];
      assign up_vld[k] = vld_pipe[k-1];
    end
    shift_levels #(.N(N), .LO(LO), .CNT(CNT)) u_lv (
      .data (sin.data),
      .amt  (sin.amt[LO +: CNT]),
      .fill (sin.fill),
      .rot  (sin.rot),
      .res  (res)
    );
    always_comb begin
      nx      = sin;
      nx.data = res;
    end
    assign nxt[k] = nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int k = 0; k <= STAGES; k++) pipe[k] <= '0;
    end else begin
      // Skid slot captures the input when stage 1 is blocked and the slot is empty,
      // or refills behind its own content when that content moves on.
      if (vld_pipe[0] == adv[1]) begin
        vld_pipe[0] <= in_valid;
        if (in_valid) pipe[0] <= pre;
      end
      for (int k = 1; k <= STAGES; k++) begin
        if (adv[k]) begin
          vld_pipe[k] <= up_vld[k];
          if (up_vld[k]) pipe[k] <= nxt[k];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) rout[i] = pipe[STAGES].data[N-1-i];
    out_data = pipe[STAGES].rev ? rout : pipe[STAGES].data;
  end
  assign out_valid   = vld_pipe[STAGES];
  assign out_tag     = pipe[STAGES].tag;
  assign out_illegal = pipe[STAGES].ill;

  logic unused_bits;
  assign unused_bits = ^{pipe[STAGES].amt, pipe[STAGES].fill, pipe[STAGES].rot};
endmodule

// File: tb/tb_shift_unit_pipelined.sv
// Self-checking bench: a STAGES=2 unit checked by scoreboard, plus STAGES=1 and
// STAGES=5 units sharing the same stimulus for latency checks.
module tb_shift_unit_pipelined;
  localparam int N  = 32;
  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid, out_ready;
  logic [N-1:0]  in_data, in_shamt;
  logic [2:0]    in_op;
  logic [TW-1:0] in_tag;

  logic in_ready, out_valid, out_illegal;
  logic [N-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic r1, v1, i1, r5, v5, i5;
  logic [N-1:0] d1, d5;
  logic [TW-1:0] t1, t5;

  shift_unit_pipelined #(.N(N), .STAGES(2), .TAG_W(TW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_illegal(out_illegal));
  shift_unit_pipelined #(.N(N), .STAGES(1), .TAG_W(TW)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1),
    .out_tag(t1), .out_illegal(i1));
  shift_unit_pipelined #(.N(N), .STAGES(5), .TAG_W(TW)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r5),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(v5), .out_ready(out_ready), .out_data(d5),
    .out_tag(t5), .out_illegal(i5));

  typedef struct {
    logic [31:0] d, s;
    logic [2:0]  op;
    logic [4:0]  tag;
    logic [31:0] exp;
    logic        ill;
  } vec_t;
  typedef struct packed { logic ill; logic [4:0] tag; logic [31:0] data; } res_t;

  res_t q[$];
  int   checks = 0, passes = 0;
  res_t held;
  logic stalled = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  function automatic vec_t mk(input logic [31:0] d, input logic [31:0] s,
                              input logic [2:0] op, input logic [4:0] tag,
                              input logic [31:0] e, input logic il);
    vec_t v;
    v.d = d; v.s = s; v.op = op; v.tag = tag; v.exp = e; v.ill = il;
    return v;
  endfunction

  // Reference: {illegal, result}
  function automatic logic [32:0] model(input logic [31:0] d, input logic [31:0] s,
                                        input logic [2:0] op);
    logic [63:0] w;
    logic [31:0] sr;
    logic [4:0]  a;
    logic        hi;
    logic [32:0] r;
    a  = s[4:0];
    hi = |s[31:5];
    sr = $signed(d) >>> a;
    case (op)
      3'd0: r = {1'b0, (hi ? 32'h0 : (d << a))};
      3'd1: r = {1'b0, (hi ? 32'h0 : (d >> a))};
      3'd2: r = {1'b0, (hi ? {32{d[31]}} : sr)};
      3'd3: begin w = {d, d} << a; r = {1'b0, w[63:32]}; end
      3'd4: begin w = {d, d} >> a; r = {1'b0, w[31:0]}; end
      default: r = {1'b1, 32'h0};
    endcase
    return r;
  endfunction

  task automatic drive_cycle(input logic v, input vec_t x, input logic ordy, output logic acc);
    @(posedge clk); #1;
    in_valid = v; in_data = x.d; in_shamt = x.s; in_op = x.op; in_tag = x.tag;
    out_ready = ordy;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) q.push_back({x.ill, x.tag, x.exp});
  endtask

  task automatic send(input vec_t x, input logic ordy);
    logic acc;
    int w = 0;
    drive_cycle(1'b1, x, ordy, acc);
    while (!acc && w < 50) begin drive_cycle(1'b1, x, ordy, acc); w++; end
    chk("send_accepted", acc, 1);
  endtask

  task automatic drain();
    logic acc;
    vec_t z = '{default: 0};
    int w = 0;
    while (q.size() != 0 && w < 100) begin drive_cycle(1'b0, z, 1'b1, acc); w++; end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic lat_chk(input string nm, input int L, input int c, input logic v,
                         input logic [31:0] d, input logic [4:0] t);
    chk({nm, "_valid"}, v, (c == L || c == L + 1));
    if (c == L)     begin chk({nm, "_data1"}, d, 32'h8000_0000); chk({nm, "_tag1"}, t, 1); end
    if (c == L + 1) begin chk({nm, "_data2"}, d, 32'hF800_0000); chk({nm, "_tag2"}, t, 2); end
  endtask

  // Scoreboard consumer and hold-stability monitor for the STAGES=2 unit.
  always @(negedge clk) begin
    if (rst) stalled <= 1'b0;
    else begin
      if (out_valid && out_ready) begin
        chk("result_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("out_data", out_data, q[0].data);
          chk("out_tag", out_tag, q[0].tag);
          chk("out_illegal", out_illegal, q[0].ill);
          void'(q.pop_front());
        end
      end
      if (out_valid && !out_ready) begin
        if (stalled) chk("stall_stable", {out_illegal, out_tag, out_data}, held);
        stalled <= 1'b1;
        held    <= {out_illegal, out_tag, out_data};
      end else stalled <= 1'b0;
    end
  end

  initial begin
    vec_t tbl[$];
    vec_t bp[4];
    vec_t t1a, t1b, z, r;
    logic acc;
    logic [32:0] m;
    int k, w;

    z = '{default: 0};
    t1a = mk(32'h0000_0001, 32'd31, 3'd0, 5'd1, 32'h8000_0000, 1'b0);
    t1b = mk(32'h8000_0000, 32'd4,  3'd2, 5'd2, 32'hF800_0000, 1'b0);
    tbl.push_back(mk(32'hFFFF_FFFF, 32'd32,        3'd0, 5'd3,  32'h0000_0000, 1'b0));
    tbl.push_back(mk(32'h8000_0001, 32'h100,       3'd2, 5'd4,  32'hFFFF_FFFF, 1'b0));
    tbl.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 3'd1, 5'd5,  32'h0000_0000, 1'b0));
    tbl.push_back(mk(32'h8000_0001, 32'd1,         3'd3, 5'd6,  32'h0000_0003, 1'b0));
    tbl.push_back(mk(32'h0000_0001, 32'd33,        3'd4, 5'd8,  32'h8000_0000, 1'b0));
    tbl.push_back(mk(32'h1234_5678, 32'd3,         3'd7, 5'd7,  32'h0000_0000, 1'b1));
    tbl.push_back(mk(32'hF000_0000, 32'd4,         3'd1, 5'd9,  32'h0F00_0000, 1'b0));
    tbl.push_back(mk(32'h1234_5678, 32'd1,         3'd5, 5'd10, 32'h0000_0000, 1'b1));
    tbl.push_back(mk(32'h1234_5678, 32'd1,         3'd6, 5'd11, 32'h0000_0000, 1'b1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(32'hA5A5_0F0F, 32'd0, 3'(i), 5'(12 + i), 32'hA5A5_0F0F, 1'b0));
    tbl.push_back(mk(32'h7FFF_FFFF, 32'h20,        3'd2, 5'd17, 32'h0000_0000, 1'b0));
    tbl.push_back(mk(32'h1234_5678, 32'h24,        3'd3, 5'd18, 32'h2345_6781, 1'b0));
    tbl.push_back(mk(32'h1234_5678, 32'd8,         3'd4, 5'd19, 32'h7812_3456, 1'b0));
    tbl.push_back(mk(32'h0000_00FF, 32'd28,        3'd0, 5'd20, 32'hF000_0000, 1'b0));
    tbl.push_back(mk(32'h8000_0000, 32'd31,        3'd2, 5'd21, 32'hFFFF_FFFF, 1'b0));

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_out_valid_s1", v1, 0);
    chk("rst_out_valid_s5", v5, 0);
    rst = 1'b0;

    // Back-to-back pair; latency checked on all three depths.
    for (int c = 0; c < 8; c++) begin
      drive_cycle(c < 2, (c == 0) ? t1a : t1b, 1'b1, acc);
      if (c < 2) chk("t1_accept", acc, 1);
      lat_chk("lat_s1", 1, c, v1, d1, t1);
      lat_chk("lat_s2", 2, c, out_valid, out_data, out_tag);
      lat_chk("lat_s5", 5, c, v5, d5, t5);
    end

    foreach (tbl[i]) send(tbl[i], 1'b1);
    drain();

    // Backpressure: 5 stalled cycles while offering 4 ops.
    for (int i = 0; i < 4; i++) begin
      m = model(32'h0F0F_0000 + 32'(i), 32'(i + 1), 3'(i));
      bp[i] = mk(32'h0F0F_0000 + 32'(i), 32'(i + 1), 3'(i), 5'(24 + i), m[31:0], m[32]);
    end
    k = 0;
    for (int c = 0; c < 5; c++) begin
      drive_cycle(k < 4, bp[(k < 4) ? k : 3], 1'b0, acc);
      if (acc) k++;
      if (c >= 3) chk("bp_in_ready_low", in_ready, 0);
    end
    chk("bp_accepted_while_full", k, 3);
    chk("bp_out_valid", out_valid, 1);
    w = 0;
    while (k < 4 && w < 20) begin
      drive_cycle(1'b1, bp[k], 1'b1, acc);
      if (acc) k++;
      w++;
    end
    chk("bp_all_accepted", k, 4);
    drain();

    // Random traffic with random backpressure.
    for (int i = 0; i < 80; i++) begin
      r.d   = $urandom;
      r.op  = 3'($urandom_range(0, 7));
      r.s   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 31));
      r.tag = 5'($urandom);
      m     = model(r.d, r.s, r.op);
      r.exp = m[31:0];
      r.ill = m[32];
      drive_cycle($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0, acc);
    end
    drain();

    // Reset with two ops in flight.
    send(t1a, 1'b0);
    send(t1b, 1'b0);
    drive_cycle(1'b0, z, 1'b0, acc);
    chk("pre_rst_out_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_tag", out_tag, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      drive_cycle(1'b0, z, 1'b1, acc);
      chk("no_stale_result", out_valid, 0);
    end
    send(tbl[3], 1'b1);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
